// File: rtl/axi_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi_pkg : shared AXI interconnect types, IDs and address decoder |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package axi_pkg;

  localparam int AXI_ADDR_W = 32;

  // Bit positions of each master inside one-hot request/grant vectors
  localparam int LOCK_M0_BIT = 0;
  localparam int LOCK_M1_BIT = 1;

  typedef enum logic [1:0] {
    LOCK_FREE = 2'd0,
    LOCK_M0   = 2'd1,
    LOCK_M1   = 2'd2
  } addr_arb_lock_t;

  typedef enum logic [1:0] {
    SLAVE_0 = 2'd0,
    SLAVE_1 = 2'd1,
    SLAVE_2 = 2'd2
  } addr_dec_result_t;

  typedef logic [3:0] axi_master_id_t;

  localparam axi_master_id_t AXI_MASTER_0_ID = 4'b0001;
  localparam axi_master_id_t AXI_MASTER_1_ID = 4'b0010;

  // Only the upper half-word selects the slave; every address maps somewhere
  function automatic addr_dec_result_t ADDR_DECODER(input logic [AXI_ADDR_W-1:0] addr);
    logic [15:0] upper;
    upper = addr[AXI_ADDR_W-1:AXI_ADDR_W-16];
    if (upper < 16'h0001)
      return SLAVE_0;
    else if (upper <= 16'h000F)
      return SLAVE_1;
    else
      return SLAVE_2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_ar_prio.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi_ar_prio : two-request tie-break, one-hot grant output         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module axi_ar_prio
  import axi_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // last_grant = 1 means M1 won last, so M0 takes a tie
  assign grant[LOCK_M0_BIT] = req[LOCK_M0_BIT] & (~req[LOCK_M1_BIT] |  last_grant);
  assign grant[LOCK_M1_BIT] = req[LOCK_M1_BIT] & (~req[LOCK_M0_BIT] | ~last_grant);

endmodule
`default_nettype wire

// File: rtl/axi_ar_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi_ar_arbiter : AR channel arbiter, 2 masters -> 3 slaves        |
// | Option macro AXI_AR_RR_EN: round-robin tie-break. Rev 1.0         |
// +------------------------------------------------------------------+
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif

module axi_ar_arbiter
  import axi_pkg::*;
#(
  parameter int NUM_SLV = 3
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic [`AXI_ID_BITS-1:0]    ARID_M0,
  input  logic [`AXI_ADDR_BITS-1:0]  ARADDR_M0,
  input  logic [`AXI_LEN_BITS-1:0]   ARLEN_M0,
  input  logic [`AXI_SIZE_BITS-1:0]  ARSIZE_M0,
  input  logic [1:0]                 ARBURST_M0,
  input  logic                       ARVALID_M0,
  output logic                       ARREADY_M0,

  input  logic [`AXI_ID_BITS-1:0]    ARID_M1,
  input  logic [`AXI_ADDR_BITS-1:0]  ARADDR_M1,
  input  logic [`AXI_LEN_BITS-1:0]   ARLEN_M1,
  input  logic [`AXI_SIZE_BITS-1:0]  ARSIZE_M1,
  input  logic [1:0]                 ARBURST_M1,
  input  logic                       ARVALID_M1,
  output logic                       ARREADY_M1,

  output logic [`AXI_IDS_BITS-1:0]   ARID_S0,
  output logic [`AXI_ADDR_BITS-1:0]  ARADDR_S0,
  output logic [`AXI_LEN_BITS-1:0]   ARLEN_S0,
  output logic [`AXI_SIZE_BITS-1:0]  ARSIZE_S0,
  output logic [1:0]                 ARBURST_S0,
  output logic                       ARVALID_S0,
  input  logic                       ARREADY_S0,

  output logic [`AXI_IDS_BITS-1:0]   ARID_S1,
  output logic [`AXI_ADDR_BITS-1:0]  ARADDR_S1,
  output logic [`AXI_LEN_BITS-1:0]   ARLEN_S1,
  output logic [`AXI_SIZE_BITS-1:0]  ARSIZE_S1,
  output logic [1:0]                 ARBURST_S1,
  output logic                       ARVALID_S1,
  input  logic                       ARREADY_S1,

  output logic [`AXI_IDS_BITS-1:0]   ARID_S2,
  output logic [`AXI_ADDR_BITS-1:0]  ARADDR_S2,
  output logic [`AXI_LEN_BITS-1:0]   ARLEN_S2,
  output logic [`AXI_SIZE_BITS-1:0]  ARSIZE_S2,
  output logic [1:0]                 ARBURST_S2,
  output logic                       ARVALID_S2,
  input  logic                       ARREADY_S2
);

  addr_arb_lock_t   state;
  addr_dec_result_t target;

  logic [1:0]         grant;
  logic [NUM_SLV-1:0] slv_ready;
  logic [NUM_SLV-1:0] slv_valid;
  logic               sel_ready;
  logic               lock_valid;
  logic               sel_m1;

  logic [`AXI_IDS_BITS-1:0]  sel_id;
  logic [`AXI_ADDR_BITS-1:0] sel_addr;
  logic [`AXI_LEN_BITS-1:0]  sel_len;
  logic [`AXI_SIZE_BITS-1:0] sel_size;
  logic [1:0]                sel_burst;

`ifdef AXI_AR_RR_EN
  logic last_grant;
`else
  localparam logic LAST_GRANT_FIXED = 1'b1;
`endif

  axi_ar_prio u_prio (
    .req        ({ARVALID_M1, ARVALID_M0}),
`ifdef AXI_AR_RR_EN
    .last_grant (last_grant),
`else
    .last_grant (LAST_GRANT_FIXED),
`endif
    .grant      (grant)
  );

  assign slv_ready = {ARREADY_S2, ARREADY_S1, ARREADY_S0};

  // Route by the registered target; the address is not re-decoded while locked
  always_comb begin
    sel_ready = 1'b0;
    case (target)
      SLAVE_0: sel_ready = slv_ready[0];
      SLAVE_1: sel_ready = slv_ready[1];
      SLAVE_2: sel_ready = slv_ready[2];
      default: sel_ready = 1'b0;
    endcase
  end

  always_comb begin
    lock_valid = 1'b0;
    if (state == LOCK_M0)
      lock_valid = ARVALID_M0;
    else if (state == LOCK_M1)
      lock_valid = ARVALID_M1;
  end

  always_comb begin
    slv_valid = '0;
    case (target)
      SLAVE_0: slv_valid[0] = lock_valid;
      SLAVE_1: slv_valid[1] = lock_valid;
      SLAVE_2: slv_valid[2] = lock_valid;
      default: slv_valid    = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= LOCK_FREE;
      target <= SLAVE_0;
`ifdef AXI_AR_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        LOCK_FREE: begin
          if (grant[LOCK_M0_BIT]) begin
            state  <= LOCK_M0;
            target <= ADDR_DECODER(ARADDR_M0);
          end else if (grant[LOCK_M1_BIT]) begin
            state  <= LOCK_M1;
            target <= ADDR_DECODER(ARADDR_M1);
          end
        end
        LOCK_M0: begin
          if (ARVALID_M0 && sel_ready) begin
            state <= LOCK_FREE;
`ifdef AXI_AR_RR_EN
            last_grant <= 1'b0;
`endif
          end
        end
        LOCK_M1: begin
          if (ARVALID_M1 && sel_ready) begin
            state <= LOCK_FREE;
`ifdef AXI_AR_RR_EN
            last_grant <= 1'b1;
`endif
          end
        end
        default: state <= LOCK_FREE;
      endcase
    end
  end

  // Payload follows the lock owner on every slave port; only ARVALID is steered
  assign sel_m1    = (state == LOCK_M1);
  assign sel_id    = sel_m1 ? {AXI_MASTER_1_ID, ARID_M1} : {AXI_MASTER_0_ID, ARID_M0};
  assign sel_addr  = sel_m1 ? ARADDR_M1  : ARADDR_M0;
  assign sel_len   = sel_m1 ? ARLEN_M1   : ARLEN_M0;
  assign sel_size  = sel_m1 ? ARSIZE_M1  : ARSIZE_M0;
  assign sel_burst = sel_m1 ? ARBURST_M1 : ARBURST_M0;

  assign ARREADY_M0 = (state == LOCK_M0) & sel_ready;
  assign ARREADY_M1 = (state == LOCK_M1) & sel_ready;

  assign ARVALID_S0 = slv_valid[0];
  assign ARVALID_S1 = slv_valid[1];
  assign ARVALID_S2 = slv_valid[2];

  assign ARID_S0    = sel_id;
  assign ARID_S1    = sel_id;
  assign ARID_S2    = sel_id;
  assign ARADDR_S0  = sel_addr;
  assign ARADDR_S1  = sel_addr;
  assign ARADDR_S2  = sel_addr;
  assign ARLEN_S0   = sel_len;
  assign ARLEN_S1   = sel_len;
  assign ARLEN_S2   = sel_len;
  assign ARSIZE_S0  = sel_size;
  assign ARSIZE_S1  = sel_size;
  assign ARSIZE_S2  = sel_size;
  assign ARBURST_S0 = sel_burst;
  assign ARBURST_S1 = sel_burst;
  assign ARBURST_S2 = sel_burst;

endmodule
`default_nettype wire

// File: tb/tb_axi_ar_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_axi_ar_arbiter : scoreboard bench for the AR arbiter           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif

module tb_axi_ar_arbiter;
  import axi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [3:0]  arid_m    [2];
  logic [31:0] araddr_m  [2];
  logic [3:0]  arlen_m   [2];
  logic [2:0]  arsize_m  [2];
  logic [1:0]  arburst_m [2];
  logic [1:0]  arvalid_m;
  logic        arready_m0, arready_m1;
  logic [1:0]  arready_m;

  logic [7:0]  arid_s    [3];
  logic [31:0] araddr_s  [3];
  logic [3:0]  arlen_s   [3];
  logic [2:0]  arsize_s  [3];
  logic [1:0]  arburst_s [3];
  logic        arvalid_s0, arvalid_s1, arvalid_s2;
  logic [2:0]  arvalid_s;
  logic [2:0]  arready_s;

  assign arready_m = {arready_m1, arready_m0};
  assign arvalid_s = {arvalid_s2, arvalid_s1, arvalid_s0};

  axi_ar_arbiter #(.NUM_SLV(3)) dut (
    .clk(clk), .rst(rst),
    .ARID_M0(arid_m[0]), .ARADDR_M0(araddr_m[0]), .ARLEN_M0(arlen_m[0]),
    .ARSIZE_M0(arsize_m[0]), .ARBURST_M0(arburst_m[0]),
    .ARVALID_M0(arvalid_m[0]), .ARREADY_M0(arready_m0),
    .ARID_M1(arid_m[1]), .ARADDR_M1(araddr_m[1]), .ARLEN_M1(arlen_m[1]),
    .ARSIZE_M1(arsize_m[1]), .ARBURST_M1(arburst_m[1]),
    .ARVALID_M1(arvalid_m[1]), .ARREADY_M1(arready_m1),
    .ARID_S0(arid_s[0]), .ARADDR_S0(araddr_s[0]), .ARLEN_S0(arlen_s[0]),
    .ARSIZE_S0(arsize_s[0]), .ARBURST_S0(arburst_s[0]),
    .ARVALID_S0(arvalid_s0), .ARREADY_S0(arready_s[0]),
    .ARID_S1(arid_s[1]), .ARADDR_S1(araddr_s[1]), .ARLEN_S1(arlen_s[1]),
    .ARSIZE_S1(arsize_s[1]), .ARBURST_S1(arburst_s[1]),
    .ARVALID_S1(arvalid_s1), .ARREADY_S1(arready_s[1]),
    .ARID_S2(arid_s[2]), .ARADDR_S2(araddr_s[2]), .ARLEN_S2(arlen_s[2]),
    .ARSIZE_S2(arsize_s[2]), .ARBURST_S2(arburst_s[2]),
    .ARVALID_S2(arvalid_s2), .ARREADY_S2(arready_s[2])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  typedef struct {
    int          m;
    int          slv;
    logic [7:0]  ids;
    logic [31:0] addr;
    logic [8:0]  attr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  function automatic int exp_slave(input logic [31:0] a);
    logic [15:0] hi;
    hi = a[31:16];
    if (hi == 16'h0000) return 0;
    if (hi < 16'h0010)  return 1;
    return 2;
  endfunction

  function automatic logic [8:0] attr_of(input int m, input logic [3:0] id);
    return {id ^ 4'hA, (m == 1) ? 3'd3 : 3'd2, (m == 1) ? 2'b10 : 2'b01};
  endfunction

  function automatic void expect_req(input int m, input logic [3:0] id, input logic [31:0] a);
    exp_t e;
    e.m    = m;
    e.slv  = exp_slave(a);
    e.ids  = {(m == 1) ? 4'b0010 : 4'b0001, id};
    e.addr = a;
    e.attr = attr_of(m, id);
    sb.push_back(e);
  endfunction

  // Slave model: pulses ARREADY after slv_lat cycles of ARVALID unless held
  logic       auto_en;
  logic [2:0] hold;
  logic [2:0] man_rdy;
  int         slv_lat;
  int         cnt [3];

  initial begin
    arready_s = 3'b000;
    for (int k = 0; k < 3; k++) cnt[k] = 0;
    forever begin
      @(posedge clk);
      #2;
      for (int k = 0; k < 3; k++) begin
        if (rst) begin
          arready_s[k] = 1'b0;
          cnt[k] = 0;
        end else if (!auto_en) begin
          arready_s[k] = man_rdy[k];
        end else if (arready_s[k]) begin
          arready_s[k] = 1'b0;
        end else if (!hold[k] && arvalid_s[k]) begin
          if (cnt[k] >= slv_lat) begin
            arready_s[k] = 1'b1;
            cnt[k] = 0;
          end else begin
            cnt[k]++;
          end
        end else begin
          cnt[k] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        if (arvalid_s[k] && arready_s[k]) begin
          check_eq("onehot_valid", $countones(arvalid_s), 1);
          if (sb.size() == 0) begin
            check_eq("sb_underflow", sb.size(), 1);
          end else begin
            mon_e = sb.pop_front();
            check_eq("sb_slave", k, mon_e.slv);
            check_eq("sb_ids", arid_s[k], mon_e.ids);
            check_eq("sb_addr", araddr_s[k], mon_e.addr);
            check_eq("sb_attr", {arlen_s[k], arsize_s[k], arburst_s[k]}, mon_e.attr);
            check_eq("sb_mready", arready_m, (mon_e.m == 1) ? 2'b10 : 2'b01);
          end
        end
      end
    end
  end

  task automatic master_req(input int m, input logic [3:0] id, input logic [31:0] a, input int budget);
    int got;
    arid_m[m]   = id;
    araddr_m[m] = a;
    {arlen_m[m], arsize_m[m], arburst_m[m]} = attr_of(m, id);
    arvalid_m[m] = 1'b1;
    got = 0;
    for (int i = 0; i < budget && got == 0; i++) begin
      @(negedge clk);
      if (arready_m[m]) got = 1;
    end
    check_eq($sformatf("grant_m%0d", m), got, 1);
    @(posedge clk);
    #1;
    arvalid_m[m] = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] dec_addr [4];

  initial begin
    rst = 1'b1;
    auto_en = 1'b0;
    hold = 3'b000;
    man_rdy = 3'b000;
    slv_lat = 1;
    arvalid_m = 2'b00;
    for (int m = 0; m < 2; m++) begin
      arid_m[m] = '0; araddr_m[m] = '0; arlen_m[m] = '0;
      arsize_m[m] = '0; arburst_m[m] = '0;
    end
    dec_addr[0] = 32'h0000_FFFF;
    dec_addr[1] = 32'h0001_0000;
    dec_addr[2] = 32'h000F_FFFC;
    dec_addr[3] = 32'h0010_0000;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_state", 64'(dut.state), 64'(LOCK_FREE));
    check_eq("rst_target", 64'(dut.target), 64'(SLAVE_0));
    step();
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("idle_out", {arvalid_s, arready_m}, 5'b0);
      check_eq("idle_state", 64'(dut.state), 64'(LOCK_FREE));
    end

    // M0 single read with exact cycle timing
    step();
    expect_req(0, 4'h3, 32'h0000_1000);
    arid_m[0] = 4'h3;
    araddr_m[0] = 32'h0000_1000;
    {arlen_m[0], arsize_m[0], arburst_m[0]} = attr_of(0, 4'h3);
    arvalid_m[0] = 1'b1;
    @(negedge clk);
    check_eq("m0_t0_valid", arvalid_s, 3'b000);
    step();
    @(negedge clk);
    check_eq("m0_t1_valid", arvalid_s, 3'b001);
    check_eq("m0_t1_id", arid_s[0], 8'h13);
    check_eq("m0_t1_ready", arready_m, 2'b00);
    step();
    step();
    man_rdy = 3'b001;
    @(negedge clk);
    check_eq("m0_t3_ready", arready_m, 2'b01);
    step();
    arvalid_m[0] = 1'b0;
    man_rdy = 3'b000;
    @(negedge clk);
    check_eq("m0_t4_valid", arvalid_s, 3'b000);
    check_eq("m0_t4_state", 64'(dut.state), 64'(LOCK_FREE));

    // Decode boundaries
    auto_en = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      expect_req(0, 4'(i + 8), dec_addr[i]);
      master_req(0, 4'(i + 8), dec_addr[i], 50);
    end

    // Held slave: M1 locked on S2 while M0 waits
    hold = 3'b100;
    expect_req(1, 4'h5, 32'h0010_0000);
    expect_req(0, 4'h6, 32'h0000_0040);
    fork
      master_req(1, 4'h5, 32'h0010_0000, 100);
      begin
        step();
        master_req(0, 4'h6, 32'h0000_0040, 100);
      end
      begin
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_eq("hold_m0_ready", arready_m, 2'b00);
        check_eq("hold_valid", arvalid_s, 3'b100);
        check_eq("hold_state", 64'(dut.state), 64'(LOCK_M1));
        check_eq("hold_target", 64'(dut.target), 64'(SLAVE_2));
        step();
        hold = 3'b000;
      end
    join

    // Reset while M1 is locked on S1
    hold = 3'b010;
    step();
    arid_m[1] = 4'h1;
    araddr_m[1] = 32'h0002_0000;
    {arlen_m[1], arsize_m[1], arburst_m[1]} = attr_of(1, 4'h1);
    arvalid_m[1] = 1'b1;
    step();
    @(negedge clk);
    check_eq("pre_rst_valid", arvalid_s, 3'b010);
    check_eq("pre_rst_id", arid_s[1], 8'h21);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    arvalid_m[1] = 1'b0;
    @(negedge clk);
    check_eq("post_rst_out", {arvalid_s, arready_m}, 5'b0);
    check_eq("post_rst_state", 64'(dut.state), 64'(LOCK_FREE));
    hold = 3'b000;
    step();
    expect_req(1, 4'h1, 32'h0002_0000);
    master_req(1, 4'h1, 32'h0002_0000, 50);

    // Back-to-back ties from both masters
`ifdef AXI_AR_RR_EN
    expect_req(0, 4'h2, 32'h0000_0000);
    expect_req(1, 4'h1, 32'h0002_0000);
    expect_req(0, 4'h4, 32'h0010_0004);
    expect_req(1, 4'h7, 32'h0000_0100);
`else
    expect_req(0, 4'h2, 32'h0000_0000);
    expect_req(0, 4'h4, 32'h0010_0004);
    expect_req(1, 4'h1, 32'h0002_0000);
    expect_req(1, 4'h7, 32'h0000_0100);
`endif
    step();
    fork
      begin
        master_req(0, 4'h2, 32'h0000_0000, 60);
        master_req(0, 4'h4, 32'h0010_0004, 60);
      end
      begin
        master_req(1, 4'h1, 32'h0002_0000, 60);
        master_req(1, 4'h7, 32'h0000_0100, 60);
      end
    join

    repeat (5) step();
    check_eq("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
